// File: rtl/class_index_receiver.sv
// class_index_receiver
//   Receives the classifier's 2-bit serial result (two beats per frame),
//   reassembles the 4-bit class index, range-checks it and buffers good
//   results in a first-word-fall-through FIFO. Flags framing errors,
//   counts good frames and, optionally, frames matching an expected label.
//
// Optional feature: define CLASS_INDEX_ACC_EN to build the label compare
//   and correct_cnt counter; otherwise correct_cnt is tied to 0.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous active-low reset
//   serial_in      result beat (beat 0 = idx[3:2], beat 1 = idx[1:0])
//   serial_valid   frame strobe, 2 cycles per frame
//   label_in       expected class, sampled on beat 1
//   result_index   FIFO head class index
//   result_valid   FIFO not empty
//   result_ready   pop head when result_valid && result_ready
//   frame_err      1-cycle pulse: truncated / over-length frame
//   range_err      1-cycle pulse: index >= NUM_CLASSES
//   overflow       sticky: good frame dropped, FIFO full
//   frame_cnt      good frames pushed (saturating)
//   correct_cnt    frames matching label_in (saturating)
module class_index_receiver #(
  parameter int NUM_CLASSES = 10,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           serial_in,
  input  logic                 serial_valid,
  input  logic [3:0]           label_in,
  output logic [3:0]           result_index,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic                 frame_err,
  output logic                 range_err,
  output logic                 overflow,
  output logic [CNT_WIDTH-1:0] frame_cnt,
  output logic [CNT_WIDTH-1:0] correct_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0]  NUM_C  = 5'(NUM_CLASSES);
  localparam logic [AW:0] FULL_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, HI, TAIL} state_e;

  state_e      state_q, state_d;
  logic [1:0]  hi_q, hi_d;
  logic        ovl_q, ovl_d;      // over-length already reported this frame
  logic        frame_err_q, frame_err_d;
  logic        range_err_q, range_err_d;
  logic        push_req;
  logic [3:0]  idx;
  logic        in_range;

  assign idx      = {hi_q, serial_in};
  assign in_range = {1'b0, idx} < NUM_C;

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    ovl_d       = ovl_q;
    frame_err_d = 1'b0;
    range_err_d = 1'b0;
    push_req    = 1'b0;
    case (state_q)
      IDLE: if (serial_valid) begin
        hi_d    = serial_in;
        state_d = HI;
      end
      HI: begin
        if (serial_valid) begin
          if (in_range) push_req    = 1'b1;
          else          range_err_d = 1'b1;
          ovl_d   = 1'b0;
          state_d = TAIL;
        end else begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end
      end
      TAIL: begin
        if (serial_valid) begin
          // extra beats are swallowed; only the first one is reported
          if (!ovl_q) frame_err_d = 1'b1;
          ovl_d = 1'b1;
        end else begin
          ovl_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      hi_q        <= '0;
      ovl_q       <= 1'b0;
      frame_err_q <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      ovl_q       <= ovl_d;
      frame_err_q <= frame_err_d;
      range_err_q <= range_err_d;
    end
  end

  assign frame_err = frame_err_q;
  assign range_err = range_err_q;

  // ---------------- result FIFO ----------------
  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          full, empty, pop, do_push, drop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_C);
  assign pop     = !empty && result_ready;
  // a simultaneous pop frees the slot, so a push into a full FIFO still lands
  assign do_push = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;

  always_comb begin
    count_d = count_q;
    case ({do_push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= idx;
  end

  logic [CNT_WIDTH-1:0] frame_cnt_q;
  logic                 overflow_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && frame_cnt_q != '1) frame_cnt_q <= frame_cnt_q + CNT_WIDTH'(1);
      if (drop)    overflow_q <= 1'b1;
    end
  end

  // storage is not reset, so mask the head while empty
  assign result_valid = !empty;
  assign result_index = empty ? 4'd0 : mem[rd_ptr_q];
  assign frame_cnt    = frame_cnt_q;
  assign overflow     = overflow_q;

`ifdef CLASS_INDEX_ACC_EN
  logic [CNT_WIDTH-1:0] correct_cnt_q;
  // counted on every in-range frame, even one the FIFO drops
  always_ff @(posedge clk) begin
    if (!reset)
      correct_cnt_q <= '0;
    else if (push_req && label_in == idx && correct_cnt_q != '1)
      correct_cnt_q <= correct_cnt_q + CNT_WIDTH'(1);
  end
  assign correct_cnt = correct_cnt_q;
`else
  logic unused_label;
  assign unused_label = ^label_in;
  assign correct_cnt  = '0;
`endif

endmodule

// File: tb/tb_class_index_receiver.sv
module tb_class_index_receiver;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  serial_in = '0;
  logic        serial_valid = 1'b0;
  logic [3:0]  label_in = 4'd15;
  logic [3:0]  result_index;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic        frame_err, range_err, overflow;
  logic [15:0] frame_cnt, correct_cnt;

  class_index_receiver #(.NUM_CLASSES(10), .FIFO_DEPTH(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .serial_in(serial_in), .serial_valid(serial_valid),
    .label_in(label_in), .result_index(result_index), .result_valid(result_valid),
    .result_ready(result_ready), .frame_err(frame_err), .range_err(range_err),
    .overflow(overflow), .frame_cnt(frame_cnt), .correct_cnt(correct_cnt));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int re_cnt = 0;
  int fe0, re0;
  int exp_q[$];

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic beat(input logic v, input logic [1:0] d);
    serial_valid = v; serial_in = d; tick();
  endtask

  task automatic send(input logic [3:0] idx, input logic [3:0] lbl);
    beat(1'b1, idx[3:2]);
    label_in = lbl;
    beat(1'b1, idx[1:0]);
    label_in = 4'd15;
    beat(1'b0, 2'b00);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    chk("drain", exp_q.size(), 0);
  endtask

  // scoreboard monitor: compares the head on every accepted pop
  always @(negedge clk) begin
    fe_cnt += int'(frame_err);
    re_cnt += int'(range_err);
    if (reset && result_valid && result_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pop: got %0d expected none", result_index);
      end else begin
        chk("pop_order", int'(result_index), exp_q.pop_front());
      end
    end
  end

  initial begin
    repeat (3) tick();
    chk("rst_valid", result_valid, 0);
    chk("rst_index", result_index, 0);
    chk("rst_errs", {frame_err, range_err, overflow}, 0);
    chk("rst_fcnt", frame_cnt, 0);
    chk("rst_ccnt", correct_cnt, 0);
    reset = 1'b1;
    tick();

    // idx 9, latency one cycle after beat 1
    fe0 = fe_cnt; re0 = re_cnt;
    beat(1'b1, 2'b10);
    exp_q.push_back(9);
    beat(1'b1, 2'b01);
    chk("lat_valid", result_valid, 1);
    chk("lat_index", result_index, 9);
    beat(1'b0, 2'b00);
    chk("f9_fcnt", frame_cnt, 1);
    chk("f9_fe", fe_cnt - fe0, 0);
    chk("f9_re", re_cnt - re0, 0);

    // idx 12: range error
    fe0 = fe_cnt; re0 = re_cnt;
    send(4'd12, 4'd15);
    chk("r12_re", re_cnt - re0, 1);
    chk("r12_fcnt", frame_cnt, 1);
    chk("r12_fe", fe_cnt - fe0, 0);

    // truncated frame
    fe0 = fe_cnt;
    beat(1'b1, 2'b01);
    beat(1'b0, 2'b00);
    beat(1'b0, 2'b00);
    chk("trunc_fe", fe_cnt - fe0, 1);
    chk("trunc_fcnt", frame_cnt, 1);
    chk("trunc_head", result_index, 9);

    // over-length frame: 00,11,01,10
    fe0 = fe_cnt;
    beat(1'b1, 2'b00);
    exp_q.push_back(3);
    beat(1'b1, 2'b11);
    beat(1'b1, 2'b01);
    chk("ovl_pulse", frame_err, 1);
    beat(1'b1, 2'b10);
    chk("ovl_once", frame_err, 0);
    beat(1'b0, 2'b00);
    chk("ovl_fe", fe_cnt - fe0, 1);
    chk("ovl_fcnt", frame_cnt, 2);
    result_ready = 1'b1;
    wait_drain();
    result_ready = 1'b0;

    // FIFO overflow, then push coinciding with a pop while full
    reset = 1'b0; exp_q.delete(); tick();
    reset = 1'b1; tick();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(i);
      send(4'(i), 4'd15);
    end
    chk("of_flag", overflow, 1);
    chk("of_fcnt", frame_cnt, 4);
    chk("of_head", result_index, 0);
    beat(1'b1, 2'b01);
    result_ready = 1'b1;
    exp_q.push_back(6);
    beat(1'b1, 2'b10);
    beat(1'b0, 2'b00);
    wait_drain();
    chk("of_fcnt6", frame_cnt, 5);
    chk("of_empty", result_valid, 0);
    chk("of_sticky", overflow, 1);

    // label compare
    exp_q.push_back(5); send(4'd5, 4'd5);
    exp_q.push_back(7); send(4'd7, 4'd5);
    exp_q.push_back(5); send(4'd5, 4'd5);
    wait_drain();
`ifdef CLASS_INDEX_ACC_EN
    chk("acc_cnt", correct_cnt, 2);
`else
    chk("acc_cnt", correct_cnt, 0);
`endif

    // reset during HI
    result_ready = 1'b0;
    exp_q.push_back(1); send(4'd1, 4'd15);
    beat(1'b1, 2'b10);
    fe0 = fe_cnt;
    reset = 1'b0; serial_valid = 1'b0; exp_q.delete();
    tick();
    chk("rh_valid", result_valid, 0);
    chk("rh_index", result_index, 0);
    chk("rh_errs", {frame_err, range_err, overflow}, 0);
    chk("rh_fcnt", frame_cnt, 0);
    chk("rh_ccnt", correct_cnt, 0);
    reset = 1'b1; tick();
    exp_q.push_back(8); send(4'd8, 4'd15);
    chk("rh_fcnt1", frame_cnt, 1);
    chk("rh_head", result_index, 8);
    chk("rh_fe", fe_cnt - fe0, 0);
    result_ready = 1'b1;
    wait_drain();
    chk("rh_empty", result_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
